pad_memory_responder: RTL and testbench

//  Responder end of the CPU pad interface: accepts pad_read/pad_write requests (byte/half/word) from the

---
 rtl/pad_pkg.sv | 42 ++++
 rtl/pad_byte_lane.sv | 34 +++
 rtl/pad_memory_responder.sv | 136 +++++++++++++
 tb/tb_pad_memory_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pad_pkg.sv
// Shared definitions for the pad memory responder: access-size codes,
// FSM state type, request record and size helpers.
package pad_pkg;

  localparam logic [1:0] PAD_BYTE  = 2'b00;
  localparam logic [1:0] PAD_HALF  = 2'b01;
  localparam logic [1:0] PAD_WORD  = 2'b11;
  localparam int         PAD_LANES = 4;

  typedef enum logic [1:0] {
    PAD_IDLE,
    PAD_ACCESS,
    PAD_DONE
  } pad_state_t;

  // Request captured at acceptance; held for the whole access.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        write;
  } pad_req_t;

  // Number of byte beats for a size code; 2'b10 behaves as a word.
  function automatic logic [2:0] pad_beats(input logic [1:0] size);
    case (size)
      PAD_BYTE: pad_beats = 3'd1;
      PAD_HALF: pad_beats = 3'd2;
      default:  pad_beats = 3'd4;
    endcase
  endfunction

  // Natural-alignment check; bytes are always aligned.
  function automatic logic pad_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      PAD_BYTE: pad_misaligned = 1'b0;
      PAD_HALF: pad_misaligned = addr_lo[0];
      default:  pad_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/pad_byte_lane.sv
// One byte lane of the pad data path: offers its store byte when the beat
// index selects it, and assembles its read byte from the memory stream.
module pad_byte_lane #(
  parameter int LANE = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       capture,
  input  logic [1:0] beat_idx,
  input  logic [7:0] wdata_byte,
  input  logic [7:0] rdata_byte,
  output logic [7:0] wsel_byte,
  output logic [7:0] lane_next
);

  logic [7:0] lane_q;
  logic       hit;

  assign hit = (beat_idx == 2'(LANE));

  // Store byte is only offered on this lane's beat so the top can OR lanes together.
  always_comb begin
    wsel_byte = hit ? wdata_byte : 8'h00;
    lane_next = (capture && hit) ? rdata_byte : lane_q;
  end

  // Staging byte: cleared at acceptance so unused upper lanes read as zero.
  always_ff @(posedge clock) begin
    if (reset || clear) lane_q <= 8'h00;
    else                lane_q <= lane_next;
  end

endmodule

// File: rtl/pad_memory_responder.sv
// Responder end of the CPU pad interface. Serializes byte/half/word pad
// accesses into little-endian byte beats on a request/ack memory port.
// Optional build macro PAD_MISALIGN_TRAP_EN: misaligned half/word accesses
// complete immediately with pad_fault instead of being split across bytes.
module pad_memory_responder
  import pad_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               pad_address,
  input  logic                      pad_read,
  input  logic                      pad_write,
  input  logic [1:0]                pad_data_size,
  input  logic [31:0]               pad_write_data,
  output logic [31:0]               pad_read_data,
  output logic                      pad_busy,
  output logic                      pad_done,
  output logic                      pad_fault,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]                mem_write_data,
  output logic                      mem_request,
  output logic                      mem_write_enable,
  input  logic [7:0]                mem_read_data,
  input  logic                      mem_ack
);

  pad_state_t state, next_state;
  pad_req_t   req_q;
  logic [2:0] beat_q;
  logic [2:0] beats_q;
  logic       accept;
  logic       trap;
  logic       beat_ack;
  logic       last_beat;

  logic [PAD_LANES-1:0][7:0] wsel;
  logic [PAD_LANES-1:0][7:0] lane_next;

  assign accept    = (state == PAD_IDLE) && (pad_read || pad_write);
  assign beat_ack  = (state == PAD_ACCESS) && mem_ack;
  assign last_beat = (beat_q == beats_q - 3'd1);

`ifdef PAD_MISALIGN_TRAP_EN
  logic fault_q;
  assign trap      = pad_misaligned(pad_data_size, pad_address[1:0]);
  assign pad_fault = (state == PAD_DONE) && fault_q;

  // Remember whether this completion is a trapped (no-beat) one.
  always_ff @(posedge clock) begin
    if (reset)       fault_q <= 1'b0;
    else if (accept) fault_q <= trap;
  end
`else
  assign trap      = 1'b0;
  assign pad_fault = 1'b0;
`endif

  // High address bits beyond the memory port are intentionally dropped.
  generate
    if (MEM_ADDR_WIDTH < 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = |req_q.addr[31:MEM_ADDR_WIDTH];
    end
  endgenerate

  // Per-lane write byte select and read byte assembly.
  generate
    for (genvar i = 0; i < PAD_LANES; i++) begin : g_lane
      pad_byte_lane #(.LANE(i)) u_lane (
        .clock      (clock),
        .reset      (reset),
        .clear      (accept),
        .capture    (beat_ack && !req_q.write),
        .beat_idx   (beat_q[1:0]),
        .wdata_byte (req_q.wdata[8*i +: 8]),
        .rdata_byte (mem_read_data),
        .wsel_byte  (wsel[i]),
        .lane_next  (lane_next[i])
      );
    end
  endgenerate

  // Next-state logic: IDLE -> ACCESS (or DONE on a trap) -> DONE -> IDLE.
  always_comb begin
    next_state = state;
    case (state)
      PAD_IDLE:   if (accept) next_state = trap ? PAD_DONE : PAD_ACCESS;
      PAD_ACCESS: if (beat_ack && last_beat) next_state = PAD_DONE;
      PAD_DONE:   next_state = PAD_IDLE;
      default:    next_state = PAD_IDLE;
    endcase
  end

  // State, request capture, beat counter and read result register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= PAD_IDLE;
      req_q         <= '0;
      beat_q        <= 3'd0;
      beats_q       <= 3'd1;
      pad_read_data <= 32'h0;
    end else begin
      state <= next_state;
      if (accept) begin
        req_q.addr  <= pad_address;
        req_q.size  <= pad_data_size;
        req_q.wdata <= pad_write_data;
        req_q.write <= pad_write;
        beats_q     <= pad_beats(pad_data_size);
        beat_q      <= 3'd0;
      end else if (beat_ack) begin
        beat_q <= beat_q + 3'd1;
      end
      // Publish on the final ack so the result is visible during DONE.
      if (beat_ack && last_beat && !req_q.write)
        pad_read_data <= lane_next;
    end
  end

  // Memory port and status outputs, decoded from state and beat index.
  always_comb begin
    pad_busy         = (state != PAD_IDLE);
    pad_done         = (state == PAD_DONE);
    mem_request      = (state == PAD_ACCESS);
    mem_write_enable = mem_request && req_q.write;
    mem_address      = '0;
    mem_write_data   = 8'h00;
    if (mem_request)
      mem_address = req_q.addr[MEM_ADDR_WIDTH-1:0] + MEM_ADDR_WIDTH'(beat_q);
    if (mem_write_enable)
      for (int i = 0; i < PAD_LANES; i++) mem_write_data |= wsel[i];
  end

endmodule

// File: tb/tb_pad_memory_responder.sv
// Self-checking bench for pad_memory_responder: directed scenarios followed
// by randomized accesses against a byte-array memory and a transaction model.
module tb_pad_memory_responder;

`ifdef PAD_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pad_address;
  logic        pad_read;
  logic        pad_write;
  logic [1:0]  pad_data_size;
  logic [31:0] pad_write_data;
  logic [31:0] pad_read_data;
  logic        pad_busy;
  logic        pad_done;
  logic        pad_fault;
  logic [15:0] mem_address;
  logic [7:0]  mem_write_data;
  logic        mem_request;
  logic        mem_write_enable;
  logic [7:0]  mem_read_data;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [0:65535];
  logic [31:0] prev_rd;

  always #5 clock = ~clock;

  pad_memory_responder #(.MEM_ADDR_WIDTH(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .pad_address      (pad_address),
    .pad_read         (pad_read),
    .pad_write        (pad_write),
    .pad_data_size    (pad_data_size),
    .pad_write_data   (pad_write_data),
    .pad_read_data    (pad_read_data),
    .pad_busy         (pad_busy),
    .pad_done         (pad_done),
    .pad_fault        (pad_fault),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_request      (mem_request),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data),
    .mem_ack          (mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One complete pad access. dly<0 picks a random ack delay per beat.
  // both: pad_read raised together with pad_write. noise: pad_read held
  // with junk address through the access and the DONE edge.
  task automatic do_access(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                           input logic [31:0] wd, input int dly, input bit both, input bit noise);
    int          nb;
    int          d;
    bit          mis;
    logic [15:0] ea;
    logic [31:0] exp_rd;
    pad_address    = a;
    pad_data_size  = sz;
    pad_write      = wr;
    pad_read       = !wr || both;
    pad_write_data = wd;
    cyc();
    pad_write = 1'b0;
    pad_read  = noise;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    if (TRAP && mis) begin
      chk("trap_done",  32'(pad_done), 32'd1);
      chk("trap_fault", 32'(pad_fault), 32'd1);
      chk("trap_noreq", 32'(mem_request), 32'd0);
      chk("trap_rd",    pad_read_data, prev_rd);
    end else begin
      exp_rd = 32'h0;
      for (int k = 0; k < nb; k++) begin
        ea = a[15:0] + 16'(k);
        d  = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        for (int c = 0; c <= d; c++) begin
          chk("beat_req",  32'(mem_request), 32'd1);
          chk("beat_addr", 32'(mem_address), 32'(ea));
          chk("beat_we",   32'(mem_write_enable), 32'(wr));
          if (wr) chk("beat_wdata", 32'(mem_write_data), 32'(wd[8*k +: 8]));
          chk("beat_nodone", 32'(pad_done), 32'd0);
          if (noise) pad_address = $urandom;
          pad_write_data = $urandom;
          mem_ack        = (c == d);
          mem_read_data  = (c == d) ? mem[ea] : 8'($urandom);
          if (c == d) begin
            if (wr) mem[ea] = wd[8*k +: 8];
            else    exp_rd  = exp_rd | (32'(mem[ea]) << (8 * k));
          end
          cyc();
          mem_ack = 1'b0;
        end
      end
      chk("done_pulse", 32'(pad_done), 32'd1);
      chk("done_busy",  32'(pad_busy), 32'd1);
      chk("done_noreq", 32'(mem_request), 32'd0);
      chk("done_fault", 32'(pad_fault), 32'd0);
      chk("done_rd",    pad_read_data, wr ? prev_rd : exp_rd);
      if (!wr) prev_rd = exp_rd;
    end
    cyc();
    pad_read = 1'b0;
    chk("idle_done", 32'(pad_done), 32'd0);
    chk("idle_busy", 32'(pad_busy), 32'd0);
    // Stray ack while idle must be ignored.
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("idle2_busy", 32'(pad_busy), 32'd0);
    chk("idle2_req",  32'(mem_request), 32'd0);
    chk("idle2_rd",   pad_read_data, prev_rd);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    reset = 1'b1; pad_address = 0; pad_read = 0; pad_write = 0;
    pad_data_size = 0; pad_write_data = 0; mem_read_data = 0; mem_ack = 0;
    prev_rd = 32'h0;
    cyc(); cyc();
    chk("rst_rd",   pad_read_data, 32'h0);
    chk("rst_busy", 32'(pad_busy), 32'd0);
    chk("rst_done", 32'(pad_done), 32'd0);
    chk("rst_flt",  32'(pad_fault), 32'd0);
    chk("rst_req",  32'(mem_request), 32'd0);
    chk("rst_we",   32'(mem_write_enable), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_wd",   32'(mem_write_data), 32'd0);
    reset = 1'b0;
    cyc();

    // Word read, ack tied high.
    mem[16'h10] = 8'h11; mem[16'h11] = 8'h22; mem[16'h12] = 8'h33; mem[16'h13] = 8'h44;
    do_access(32'h0000_0010, 2'b11, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    chk("t1_word", pad_read_data, 32'h4433_2211);

    // Byte write; read result must not move.
    do_access(32'h0000_0007, 2'b00, 1'b1, 32'hAABB_CCDD, 0, 1'b0, 1'b0);
    chk("t2_mem", 32'(mem[16'h0007]), 32'hDD);
    chk("t2_rd",  pad_read_data, 32'h4433_2211);

    // Half read wrapping the top of memory, slow acks.
    mem[16'hFFFF] = 8'hA5; mem[16'h0000] = 8'h5A;
    do_access(32'h0000_FFFF, 2'b01, 1'b0, 32'h0, 3, 1'b0, 1'b0);
    if (!TRAP) chk("t3_half", pad_read_data, 32'h0000_5AA5);

    // Read and write together: write wins; later requests while busy ignored.
    do_access(32'h0000_0020, 2'b11, 1'b1, 32'h1234_5678, -1, 1'b1, 1'b1);

    // Reset in the middle of a word read.
    pad_address = 32'h40; pad_data_size = 2'b11; pad_read = 1'b1;
    cyc();
    pad_read = 1'b0;
    mem_ack = 1'b1; mem_read_data = 8'h77;
    cyc(); cyc();
    mem_ack = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;
    prev_rd = 32'h0;
    chk("t5_req",  32'(mem_request), 32'd0);
    chk("t5_busy", 32'(pad_busy), 32'd0);
    chk("t5_rd",   pad_read_data, 32'h0);
    chk("t5_done", 32'(pad_done), 32'd0);
    cyc();
    chk("t5_idle", 32'(pad_busy), 32'd0);

    // Misaligned word read.
    do_access(32'h0000_0002, 2'b11, 1'b0, 32'h0, 0, 1'b0, 1'b0);

    // Randomized accesses, including the 2'b10 size code.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      if (n % 3 == 0) ra[15:0] = 16'hFFFC + 16'($urandom_range(0, 3));
      do_access(ra, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
